// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM slot arbiter: FSM states, grant encoding,
// bus widths and the registered SDRAM request bundle.
package sdram_arb_pkg;

  localparam int unsigned SlotLenDef   = 10;
  localparam int unsigned RdLatDef     = 7;
  localparam int unsigned RefSlotsDef  = 50;
  localparam int unsigned StarveMaxDef = 3;

  localparam int unsigned AddrW = 22;
  localparam int unsigned DataW = 16;
  localparam int unsigned DsW   = 2;
  localparam int unsigned PendW = 3;

  localparam logic [PendW-1:0] PendUrgent = 3'd4;
  localparam logic [PendW-1:0] PendMax    = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StSlotA,
    StSlotB,
    StSlotRef
  } arb_state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntA,
    GntB,
    GntRef
  } grant_e;

  typedef struct packed {
    logic             we;
    logic [AddrW-1:0] addr;
    logic [DsW-1:0]   ds;
    logic [DataW-1:0] din;
  } ram_req_t;

  function automatic arb_state_e grant_to_state(input grant_e gnt);
    arb_state_e st;
    unique case (gnt)
      GntA:    st = StSlotA;
      GntB:    st = StSlotB;
      GntRef:  st = StSlotRef;
      default: st = StIdle;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Counts slot_start pulses and raises the number of pending refreshes every REF_SLOTS
// pulses (saturating); a granted refresh slot consumes one.
module sdram_refresh_timer
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REF_SLOTS = RefSlotsDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             dec_i,
  output logic [PendW-1:0] pending_o
);

  localparam int unsigned TimerW = (REF_SLOTS > 1) ? $clog2(REF_SLOTS) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(REF_SLOTS - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic [PendW-1:0]  pending_q, pending_d;
  logic              inc;

  always_comb begin
    timer_d = timer_q;
    inc     = 1'b0;
    if (tick_i) begin
      if (timer_q == TimerLast) begin
        timer_d = '0;
        inc     = 1'b1;
      end else begin
        timer_d = timer_q + TimerW'(1);
      end
    end
  end

  // Simultaneous increment and decrement cancel out.
  always_comb begin
    pending_d = pending_q;
    unique case ({inc, dec_i})
      2'b10: if (pending_q != PendMax) pending_d = pending_q + PendW'(1);
      2'b01: if (pending_q != '0) pending_d = pending_q - PendW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q   <= '0;
      pending_q <= '0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Slot-based SDRAM arbiter between chipset port A, CPU/DMA port B and refresh.
// Define SDRAM_ARB_FAIRNESS_EN to let a starved port B override port A.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned SLOT_LEN   = SlotLenDef,
  parameter int unsigned RD_LAT     = RdLatDef,
  parameter int unsigned REF_SLOTS  = RefSlotsDef,
  parameter int unsigned STARVE_MAX = StarveMaxDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mem_ready_i,
  input  logic             slot_start_i,
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [DsW-1:0]   a_ds_i,
  input  logic [DataW-1:0] a_din_i,
  output logic             a_ack_o,
  output logic [DataW-1:0] a_dout_o,
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [DsW-1:0]   b_ds_i,
  input  logic [DataW-1:0] b_din_i,
  output logic             b_ack_o,
  output logic [DataW-1:0] b_dout_o,
  output logic             ram_cs_o,
  output logic             ram_we_o,
  output logic             ram_refresh_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [DsW-1:0]   ram_ds_o,
  output logic [DataW-1:0] ram_din_o,
  input  logic [DataW-1:0] ram_dout_i,
  output logic             overrun_o
);

  localparam int unsigned CntW = $clog2(SLOT_LEN);
  localparam logic [CntW-1:0] CntLast = CntW'(SLOT_LEN - 1);
  localparam logic [CntW-1:0] CntRd   = CntW'(RD_LAT);
  localparam logic [CntW-1:0] CntWr   = CntW'(1);

  arb_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  ram_req_t         req_q, req_d;
  logic             cs_q, cs_d, refresh_q, refresh_d;
  logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DataW-1:0] a_dout_q, a_dout_d, b_dout_q, b_dout_d;
  logic             overrun_q, overrun_d;
  logic [PendW-1:0] pending;
  logic             grant_ev, starving, ack_hit;
  grant_e           gnt;
  ram_req_t         a_bus, b_bus;

  assign a_bus = '{we: a_we_i, addr: a_addr_i, ds: a_ds_i, din: a_din_i};
  assign b_bus = '{we: b_we_i, addr: b_addr_i, ds: b_ds_i, din: b_din_i};

  assign grant_ev = (state_q == StIdle) && slot_start_i && mem_ready_i;

  always_comb begin
    gnt = GntNone;
    if (grant_ev) begin
      if (pending >= PendUrgent)    gnt = GntRef;
      else if (starving && b_req_i) gnt = GntB;
      else if (a_req_i)             gnt = GntA;
      else if (b_req_i)             gnt = GntB;
      else if (pending != '0)       gnt = GntRef;
    end
  end

`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam int unsigned StW = $clog2(STARVE_MAX + 1);
  localparam logic [StW-1:0] StMax = StW'(STARVE_MAX);

  logic [StW-1:0] starve_q, starve_d;

  assign starving = (starve_q == StMax);

  always_comb begin
    starve_d = starve_q;
    if (gnt == GntB) begin
      starve_d = '0;
    end else if (gnt == GntA && b_req_i && starve_q != StMax) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  assign starving = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != GntNone) begin
          state_d = grant_to_state(gnt);
          cnt_d   = CntW'(1);
        end
      end
      default: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  // The winner's request is latched once at grant and held for the whole slot.
  always_comb begin
    req_d     = req_q;
    cs_d      = cs_q;
    refresh_d = refresh_q;
    unique case (gnt)
      GntA: begin
        req_d     = a_bus;
        cs_d      = 1'b1;
        refresh_d = 1'b0;
      end
      GntB: begin
        req_d     = b_bus;
        cs_d      = 1'b1;
        refresh_d = 1'b0;
      end
      GntRef: begin
        req_d.we  = 1'b0;
        cs_d      = 1'b1;
        refresh_d = 1'b1;
      end
      default: begin
        if (state_q != StIdle && state_d == StIdle) begin
          req_d.we  = 1'b0;
          cs_d      = 1'b0;
          refresh_d = 1'b0;
        end
      end
    endcase
  end

  // Acks are registered so they appear in the cycle whose count equals the target.
  always_comb begin
    ack_hit   = (cnt_d == (req_d.we ? CntWr : CntRd));
    a_ack_d   = ack_hit && (state_d == StSlotA);
    b_ack_d   = ack_hit && (state_d == StSlotB);
    a_dout_d  = (a_ack_d && !req_d.we) ? ram_dout_i : a_dout_q;
    b_dout_d  = (b_ack_d && !req_d.we) ? ram_dout_i : b_dout_q;
    overrun_d = overrun_q | (slot_start_i && state_q != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= '0;
      cs_q      <= 1'b0;
      refresh_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_dout_q  <= '0;
      b_dout_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      cs_q      <= cs_d;
      refresh_q <= refresh_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_dout_q  <= a_dout_d;
      b_dout_q  <= b_dout_d;
      overrun_q <= overrun_d;
    end
  end

  sdram_refresh_timer #(
    .REF_SLOTS(REF_SLOTS)
  ) u_refresh_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tick_i   (slot_start_i),
    .dec_i    (gnt == GntRef),
    .pending_o(pending)
  );

  assign a_ack_o       = a_ack_q;
  assign a_dout_o      = a_dout_q;
  assign b_ack_o       = b_ack_q;
  assign b_dout_o      = b_dout_q;
  assign ram_cs_o      = cs_q;
  assign ram_we_o      = req_q.we;
  assign ram_refresh_o = refresh_q;
  assign ram_addr_o    = req_q.addr;
  assign ram_ds_o      = req_q.ds;
  assign ram_din_o     = req_q.din;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized slots,
// all checked against a slot-level reference model of the arbitration rules.
module tb_sdram_arbiter;

  localparam int unsigned SLOT_LEN   = 10;
  localparam int unsigned RD_LAT     = 7;
  localparam int unsigned REF_SLOTS  = 50;
  localparam int unsigned STARVE_MAX = 3;
  localparam int WNone = 0, WA = 1, WB = 2, WRef = 3;
`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam bit Fair = 1'b1;
`else
  localparam bit Fair = 1'b0;
`endif

  typedef struct packed {
    logic        req;
    logic        we;
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
  } port_t;

  logic        clk = 1'b0;
  logic        rst_n, mem_ready, slot_start;
  logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [21:0] a_addr, b_addr, ram_addr;
  logic [1:0]  a_ds, b_ds, ram_ds;
  logic [15:0] a_din, b_din, a_dout, b_dout, ram_din, ram_dout;
  logic        ram_cs, ram_we, ram_refresh, overrun;

  int tests = 0, fails = 0;
  int pend, rcnt, starve, obs_ref, obs_b;
  logic [15:0] exp_adout, exp_bdout;
  bit exp_ovr;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .SLOT_LEN  (SLOT_LEN),
    .RD_LAT    (RD_LAT),
    .REF_SLOTS (REF_SLOTS),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_ready_i  (mem_ready),
    .slot_start_i (slot_start),
    .a_req_i      (a_req),
    .a_we_i       (a_we),
    .a_addr_i     (a_addr),
    .a_ds_i       (a_ds),
    .a_din_i      (a_din),
    .a_ack_o      (a_ack),
    .a_dout_o     (a_dout),
    .b_req_i      (b_req),
    .b_we_i       (b_we),
    .b_addr_i     (b_addr),
    .b_ds_i       (b_ds),
    .b_din_i      (b_din),
    .b_ack_o      (b_ack),
    .b_dout_o     (b_dout),
    .ram_cs_o     (ram_cs),
    .ram_we_o     (ram_we),
    .ram_refresh_o(ram_refresh),
    .ram_addr_o   (ram_addr),
    .ram_ds_o     (ram_ds),
    .ram_din_o    (ram_din),
    .ram_dout_i   (ram_dout),
    .overrun_o    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic port_t mk(input logic r, input logic w, input logic [21:0] ad,
                               input logic [1:0] s, input logic [15:0] d);
    mk = '{req: r, we: w, addr: ad, ds: s, din: d};
  endfunction

  function automatic port_t rnd_port();
    port_t p;
    p.req  = ($urandom_range(0, 2) != 0);
    p.we   = 1'($urandom_range(0, 1));
    p.addr = 22'($urandom());
    p.ds   = 2'($urandom());
    p.din  = 16'($urandom());
    return p;
  endfunction

  // Refresh bookkeeping: every REF_SLOTS-th slot_start pulse adds one pending refresh.
  function automatic bit model_pulse();
    rcnt++;
    if (rcnt == REF_SLOTS) begin
      rcnt = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    pend = 0; rcnt = 0; starve = 0;
    exp_adout = '0; exp_bdout = '0; exp_ovr = 1'b0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cs"}, ram_cs, 0);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_ref"}, ram_refresh, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_aack"}, a_ack, 0);
    check({tag, "_back"}, b_ack, 0);
    check({tag, "_adout"}, a_dout, 0);
    check({tag, "_bdout"}, b_dout, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  // One full slot: slot_start, model decision, then per-count checks until idle again.
  // A nonzero extra issues a second slot_start at that count (must be ignored).
  task automatic run_slot(input logic mr, input port_t pa, input port_t pb,
                          input logic [15:0] rd, input int extra);
    int w;
    bit inc;
    port_t p;
    mem_ready = mr;
    a_req = pa.req; a_we = pa.we; a_addr = pa.addr; a_ds = pa.ds; a_din = pa.din;
    b_req = pb.req; b_we = pb.we; b_addr = pb.addr; b_ds = pb.ds; b_din = pb.din;
    ram_dout = rd;
    w = WNone;
    if (mr) begin
      if (pend >= 4)                                   w = WRef;
      else if (Fair && pb.req && starve >= STARVE_MAX) w = WB;
      else if (pa.req)                                 w = WA;
      else if (pb.req)                                 w = WB;
      else if (pend >= 1)                              w = WRef;
    end
    inc = model_pulse();
    if (w == WRef) pend--;
    if (inc && pend < 7) pend++;
    if (Fair) begin
      if (w == WB) starve = 0;
      else if (w == WA && pb.req && starve < STARVE_MAX) starve++;
    end
    p = (w == WB) ? pb : pa;
    slot_start = 1'b1;
    tick();
    slot_start = 1'b0;
    for (int k = 1; k < SLOT_LEN; k++) begin
      if (k == RD_LAT && w == WA && !pa.we) exp_adout = rd;
      if (k == RD_LAT && w == WB && !pb.we) exp_bdout = rd;
      check("ram_cs", ram_cs, w != WNone);
      check("ram_refresh", ram_refresh, w == WRef);
      check("a_ack", a_ack, w == WA && k == (pa.we ? 1 : RD_LAT));
      check("b_ack", b_ack, w == WB && k == (pb.we ? 1 : RD_LAT));
      if (w == WA || w == WB) begin
        check("ram_addr", ram_addr, p.addr);
        check("ram_we", ram_we, p.we);
        check("ram_ds", ram_ds, p.ds);
        check("ram_din", ram_din, p.din);
      end else if (w == WRef) begin
        check("ram_we_ref", ram_we, 0);
      end
      if (k == RD_LAT) begin
        check("a_dout", a_dout, exp_adout);
        check("b_dout", b_dout, exp_bdout);
      end
      if (b_ack) obs_b++;
      if (k == 1 && ram_refresh) obs_ref++;
      if (k == extra) slot_start = 1'b1;
      tick();
      if (k == extra) begin
        slot_start = 1'b0;
        if (model_pulse() && pend < 7) pend++;
        exp_ovr = 1'b1;
      end
    end
    check("idle_cs", ram_cs, 0);
    check("idle_refresh", ram_refresh, 0);
    check("overrun", overrun, exp_ovr);
    check("end_a_dout", a_dout, exp_adout);
    check("end_b_dout", b_dout, exp_bdout);
  endtask

  initial begin
    port_t none, pa, pb;
    none = '0;
    rst_n = 1'b0; mem_ready = 1'b0; slot_start = 1'b0; ram_dout = '0;
    a_req = 0; a_we = 0; a_addr = '0; a_ds = '0; a_din = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_ds = '0; b_din = '0;
    model_reset();
    obs_ref = 0; obs_b = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // A read at 0x000123 returning 0xBEEF
    run_slot(1'b1, mk(1, 0, 22'h000123, 2'b11, 16'h0), none, 16'hBEEF, 0);
    // A and B collide: A first, then B alone
    run_slot(1'b1, mk(1, 0, 22'h000200, 2'b11, 16'h0), mk(1, 0, 22'h3F0000, 2'b01, 16'h0),
             16'h1111, 0);
    obs_b = 0;
    run_slot(1'b1, none, mk(1, 0, 22'h3F0000, 2'b01, 16'h0), 16'h2222, 0);
    check("b_single_ack", obs_b, 1);
    // A write: ack at count 1, dout untouched
    run_slot(1'b1, mk(1, 1, 22'h0ABCDE, 2'b10, 16'hCAFE), none, 16'h3333, 0);
    // Second slot_start at count 3 is ignored and flags overrun
    run_slot(1'b1, mk(1, 0, 22'h000042, 2'b11, 16'h0), none, 16'h4444, 3);

    // Asynchronous reset at count 5 of a B read
    a_req = 0; b_req = 1; b_we = 0; b_addr = 22'h2AAAA; b_ds = 2'b11; mem_ready = 1;
    ram_dout = 16'h5A5A;
    slot_start = 1'b1;
    tick();
    slot_start = 1'b0;
    check("rst_pre_cs", ram_cs, 1);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    b_req = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      check("postrst_back", b_ack, 0);
      check("postrst_cs", ram_cs, 0);
      tick();
    end

    // First grant after release, then idle slots until one refresh
    run_slot(1'b1, mk(1, 0, 22'h000777, 2'b11, 16'h0), none, 16'h6666, 0);
    obs_ref = 0;
    for (int i = 0; i < 51; i++) run_slot(1'b1, none, none, 16'h0, 0);
    check("idle_refresh_count", obs_ref, 1);

    // Both ports always requesting
    obs_b = 0;
    for (int i = 0; i < 12; i++) begin
      run_slot(1'b1, mk(1, 0, 22'(i), 2'b11, 16'h0), mk(1, 1, 22'(i + 100), 2'b11, 16'(i)),
               16'(i * 3), 0);
    end
    check("fair_b_grants", obs_b, Fair ? 3 : 0);

    // A saturating the bus: pending refresh must eventually force a refresh slot
    obs_ref = 0;
    for (int i = 0; i < 210; i++) begin
      run_slot(1'b1, mk(1, i[0], 22'($urandom()), 2'b11, 16'(i)), none, 16'($urandom()), 0);
    end
    check("forced_refresh_count", obs_ref, 1);

    // mem_ready low: no grant
    run_slot(1'b0, mk(1, 0, 22'h1, 2'b11, 16'h0), mk(1, 0, 22'h2, 2'b11, 16'h0), 16'h7777, 0);

    for (int i = 0; i < 150; i++) begin
      pa = rnd_port();
      pb = rnd_port();
      run_slot(($urandom_range(0, 7) != 0), pa, pb, 16'($urandom()),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, SLOT_LEN - 1)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
